// File: rtl/conv2_acc_requant.sv
// conv2_acc_requant: accumulates N_TAPS signed products plus a bias per output
// pixel, then rounds, shifts, optionally applies ReLU and saturates to OUT_W.
module conv2_acc_requant #(
  parameter int PROD_W  = 23,
  parameter int BIAS_W  = 14,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 9,
  parameter int N_TAPS  = 9,
  parameter int SHIFT   = 8,
  parameter int RELU_EN = 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [BIAS_W-1:0] bias_data,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

  localparam logic signed [ACC_W-1:0] RND     = {{(ACC_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {
    S_ACC,
    S_OUT
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]         out_q, out_d;
  logic                     busy_q, busy_d;

  logic signed [ACC_W-1:0]  prod_ext, bias_ext, sum, r;
  logic [OUT_W-1:0]         sat;
  logic                     prod_fire, last_tap;

  // Running sum including the product being accepted, and its requantised value.
  always_comb begin
    prod_ext = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
    bias_ext = {{(ACC_W-BIAS_W){bias_data[BIAS_W-1]}}, bias_data};
    sum      = ((cnt_q == '0) ? bias_ext : acc_q) + prod_ext;
    r        = (sum + RND) >>> SHIFT;
    if ((RELU_EN != 0) && r[ACC_W-1]) begin
      r = '0;
    end
    if (r > OUT_MAX) begin
      sat = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (r < OUT_MIN) begin
      sat = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      sat = r[OUT_W-1:0];
    end
  end

  // Next-state logic: accumulate in S_ACC, hold the result in S_OUT until taken.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_d      = out_q;
    busy_d     = busy_q;
    prod_ready = (state_q == S_ACC);
    out_valid  = (state_q == S_OUT);
    prod_fire  = prod_valid && (state_q == S_ACC);
    last_tap   = (cnt_q == CNT_W'(N_TAPS - 1));
    case (state_q)
      S_ACC: begin
        if (prod_fire) begin
          acc_d  = sum;
          busy_d = 1'b1;
          if (last_tap) begin
            cnt_d   = '0;
            out_d   = sat;
            state_d = S_OUT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          busy_d  = 1'b0;
          state_d = S_ACC;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= S_ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign out_data = out_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_conv2_acc_requant.sv
// Bench for conv2_acc_requant: two instances (ReLU on / off) share stimulus;
// a scoreboard of expected frame sums feeds an arithmetic requantisation model.
module tb_conv2_acc_requant;

  localparam int SHIFT = 8;
  localparam int OUT_W = 9;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic [22:0] prod_data;
  logic        prod_valid;
  logic [13:0] bias_data;
  logic        out_ready;

  logic        r_prod_ready, l_prod_ready;
  logic [8:0]  r_out_data, l_out_data;
  logic        r_out_valid, l_out_valid;
  logic        r_busy, l_busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  longint      exp_q[$];
  longint      last_lin, last_relu;

  always #5 ap_clk = ~ap_clk;

  conv2_acc_requant #(.RELU_EN(1)) dut_relu (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .prod_data(prod_data), .prod_valid(prod_valid), .prod_ready(r_prod_ready),
    .bias_data(bias_data),
    .out_data(r_out_data), .out_valid(r_out_valid), .out_ready(out_ready),
    .busy(r_busy)
  );

  conv2_acc_requant #(.RELU_EN(0)) dut_lin (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .prod_data(prod_data), .prod_valid(prod_valid), .prod_ready(l_prod_ready),
    .bias_data(bias_data),
    .out_data(l_out_data), .out_valid(l_out_valid), .out_ready(out_ready),
    .busy(l_busy)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout/unexpected event, expected normal progress", nm);
  endtask

  // Reference requantisation using floor division on plain integers.
  function automatic longint requant(input longint s, input bit relu);
    longint t, q, d;
    d = longint'(1) << SHIFT;
    t = s + (d / 2);
    q = t / d;
    if (t < 0 && (t % d) != 0) q = q - 1;
    if (relu && q < 0) q = 0;
    if (q > (2 ** (OUT_W - 1)) - 1) q = (2 ** (OUT_W - 1)) - 1;
    if (q < -(2 ** (OUT_W - 1))) q = -(2 ** (OUT_W - 1));
    return q;
  endfunction

  // Output checker: whenever a result is presented, compare it with the model.
  always @(negedge ap_clk) begin
    #2;
    if (ap_rst_n && (l_out_valid || r_out_valid)) begin
      chk("valid_match", r_out_valid, l_out_valid);
      if (exp_q.size() == 0) begin
        fail("out_without_frame");
      end else begin
        chk("out_lin", $signed(l_out_data), requant(exp_q[0], 1'b0));
        chk("out_relu", $signed(r_out_data), requant(exp_q[0], 1'b1));
        chk("prod_ready_in_out", l_prod_ready | r_prod_ready, 0);
        chk("busy_in_out", l_busy & r_busy, 1);
        if (out_ready) begin
          last_lin  = $signed(l_out_data);
          last_relu = $signed(r_out_data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Drives n products; entered and left at a falling edge.
  task automatic send_frame(input int p[9], input int bias, input int n, input bit gaps);
    int     waitc;
    int     g;
    longint s;
    s = bias;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 3);
        prod_valid = 1'b0;
        repeat (g) @(negedge ap_clk);
      end
      prod_valid = 1'b1;
      prod_data  = 23'(p[i]);
      bias_data  = (i == 0) ? 14'(bias) : 14'($urandom);
      waitc = 0;
      while (!l_prod_ready && waitc < 50) begin
        @(negedge ap_clk);
        waitc++;
      end
      if (!l_prod_ready) begin
        fail("prod_ready_timeout");
        prod_valid = 1'b0;
        return;
      end
      s += p[i];
      if (i == n - 1 && n == 9) exp_q.push_back(s);
      @(posedge ap_clk);
      @(negedge ap_clk);
      if (i == 0) chk("busy_after_first", l_busy & r_busy, 1);
    end
    prod_valid = 1'b0;
    if (n == 9) begin
      chk("latency_lin", l_out_valid, 1);
      chk("latency_relu", r_out_valid, 1);
    end
  endtask

  task automatic finish_frame(input string nm, input longint e_lin, input longint e_relu);
    int waitc;
    waitc = 0;
    while (exp_q.size() != 0 && waitc < 50) begin
      @(negedge ap_clk);
      waitc++;
    end
    if (exp_q.size() != 0) begin
      fail({nm, "_drain"});
    end else begin
      chk({nm, "_lin"}, last_lin, e_lin);
      chk({nm, "_relu"}, last_relu, e_relu);
      chk({nm, "_busy_clear"}, l_busy | r_busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f[9];
    ap_rst_n   = 1'b0;
    prod_valid = 1'b0;
    prod_data  = '0;
    bias_data  = '0;
    out_ready  = 1'b1;
    repeat (3) @(negedge ap_clk);
    chk("rst_out_valid", l_out_valid | r_out_valid, 0);
    chk("rst_busy", l_busy | r_busy, 0);
    chk("rst_out_data", l_out_data | r_out_data, 0);
    chk("rst_prod_ready", l_prod_ready & r_prod_ready, 1);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    chk("model_pin_383", requant(383, 1'b0), 1);
    chk("model_pin_neg", requant(-9000, 1'b0), -35);

    f = '{default: 256};
    send_frame(f, 0, 9, 1'b0);
    finish_frame("basic", 9, 9);

    f = '{default: 0}; f[0] = 384;
    send_frame(f, 0, 9, 1'b0);
    finish_frame("round_384", 2, 2);

    f[0] = 383;
    send_frame(f, 0, 9, 1'b0);
    finish_frame("round_383", 1, 1);

    f[0] = -384;
    send_frame(f, 0, 9, 1'b0);
    finish_frame("round_m384", -1, 0);

    f = '{default: 0};
    send_frame(f, 640, 9, 1'b0);
    finish_frame("bias_640", 3, 3);

    f = '{default: -1000};
    send_frame(f, 0, 9, 1'b0);
    finish_frame("neg_1000", -35, 0);

    f = '{default: 4194303};
    send_frame(f, 8191, 9, 1'b0);
    finish_frame("sat_pos", 255, 255);

    f = '{default: -4194304};
    send_frame(f, 0, 9, 1'b0);
    finish_frame("sat_neg", -256, 0);

    // Backpressure: hold the result while a new product waits at the input.
    out_ready = 1'b0;
    f = '{default: 256};
    send_frame(f, 0, 9, 1'b0);
    prod_valid = 1'b1;
    prod_data  = 23'(1000);
    bias_data  = '0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_prod_ready", l_prod_ready | r_prod_ready, 0);
      chk("bp_hold_data", $signed(l_out_data), 9);
      chk("bp_hold_valid", l_out_valid & r_out_valid, 1);
      @(negedge ap_clk);
    end
    out_ready = 1'b1;
    @(negedge ap_clk);
    chk("bp_restart_ready", l_prod_ready & r_prod_ready, 1);
    chk("bp_result_lin", last_lin, 9);
    f = '{default: 0}; f[0] = 1000;
    send_frame(f, 0, 9, 1'b0);
    finish_frame("bp_next", 4, 4);

    // Reset mid-frame, then a frame with bubbles.
    f = '{default: 256};
    send_frame(f, 0, 4, 1'b0);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    chk("midrst_out_valid", l_out_valid | r_out_valid, 0);
    chk("midrst_busy", l_busy | r_busy, 0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("midrst_ready", l_prod_ready & r_prod_ready, 1);
    send_frame(f, 0, 9, 1'b1);
    finish_frame("bubbles", 9, 9);

    repeat (3) @(negedge ap_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
